parity_tx_ctrl: RTL and testbench
=================================

PARITY_TX_CTRL -- requirements
Module: parity_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal values 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port in_data  input  8  byte to transmit.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port odd_sel  input  1  parity mode; 0 = even, 1 = odd.
REQ-007 SHALL have port in_ready  output  1  block can accept a byte.
REQ-008 SHALL have port tx  output  1  serial line; idles high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port frame_cnt  output  16  count of completed frames.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL drive in_ready = 1 only in IDLE; accept a byte on the edge where in_valid && in_ready.
REQ-014 SHALL, on acceptance, latch in_data and odd_sel; later changes to either are ignored until the next acceptance.
REQ-015 SHALL register the parity bit at acceptance as (XOR of all 8 latched data bits) XOR odd_sel, giving even or odd total-ones parity.
REQ-016 SHALL enter START on the cycle after acceptance, and drive tx = 0 for CLKS_PER_BIT cycles.
REQ-017 SHALL drive DATA bits LSB first, each held CLKS_PER_BIT cycles; bit index 0..7 is tracked by a 3-bit counter; exit after bit 7.
REQ-018 SHALL drive the parity bit for CLKS_PER_BIT cycles in PARITY.
REQ-019 SHALL drive tx = 1 for CLKS_PER_BIT cycles in STOP.
REQ-020 SHALL drive tx = 1 in IDLE.
REQ-021 SHALL count bit time with a down-counter reloaded to CLKS_PER_BIT-1 at every state or bit change; with CLKS_PER_BIT = 1, every bit lasts exactly one cycle.
REQ-022 SHALL give each frame exactly 11*CLKS_PER_BIT cycles with busy = 1 (START through STOP); busy = 0 in IDLE.
REQ-023 SHALL assert done for exactly one cycle, on the last STOP cycle.
REQ-024 SHALL increment frame_cnt on that same edge, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL return to IDLE after STOP, so the minimum inter-frame gap is one idle cycle (tx = 1, in_ready = 1).
REQ-026 SHALL, when in_valid is held high continuously, accept the next byte in that idle cycle.
REQ-027 SHALL ignore in_valid while busy; bytes presented then are neither latched nor lost-counted.
REQ-028 SHALL drive tx, busy and done from registers, with no combinational path from inputs to these outputs; in_ready is a pure decode of the current state.

Reset
REQ-029 SHALL, with rst high at a clock edge, force: state IDLE, tx = 1, busy = 0, done = 0, in_ready = 1 (from the following cycle), frame_cnt = 0, and all internal counters = 0.
REQ-030 SHALL, on reset mid-frame, abort the frame on the next edge with tx = 1; no done pulse and no frame_cnt increment occur.
REQ-031 SHALL let rst take priority over a simultaneous in_valid; no byte is accepted on a reset edge.

Verification
REQ-032 SHALL cover: CLKS_PER_BIT = 4, in_data = 0xA5, odd_sel = 0 -> tx sampled mid-bit = 0,1,0,1,0,0,1,0,1,0,1; busy high 44 cycles; done pulses once; frame_cnt = 1.
REQ-033 SHALL cover: in_data = 0x07 sent with odd_sel = 0, then with odd_sel = 1 -> parity bit 1, then 0; odd_sel toggled mid-frame has no effect on the frame in progress.
REQ-034 SHALL cover: in_valid held high with 3 bytes 0x00, 0xFF, 0x3C -> exactly one idle cycle between frames; parity bits 0, 0, 0 (even); frame_cnt = 3.
REQ-035 SHALL cover: rst asserted during DATA bit 3 of 0x5A -> tx = 1, busy = 0 on the next cycle; no done pulse; frame_cnt unchanged at 0; the next byte is sent correctly.
REQ-036 SHALL cover: CLKS_PER_BIT = 1 build, in_data = 0x80 -> frame is 11 cycles, tx = 0,0,0,0,0,0,0,0,1,1,1.
REQ-037 SHALL cover: frame_cnt preloaded via 65535 frames (or forced) -> the next done wraps it to 0x0000.

Source files
------------

// File: rtl/parity_tx_ctrl.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Each bit lasts CLKS_PER_BIT cycles. tx, busy and done come straight from flops.
module parity_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        odd_sel,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned FCNT_W = 16;

    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   data_q;
    logic                parity_q;
    logic [FCNT_W-1:0]   frame_cnt_q;
    logic                tx_d, busy_d, done_d;
    logic                bit_end;
    logic                accept;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && (state_q == IDLE);
    assign frame_cnt = frame_cnt_q;

    // Next state, bit timing and the next values of the registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        bit_end = (cnt_q == '0);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? BIT_RELOAD : cnt_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = START;
                    cnt_d   = BIT_RELOAD;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered so they line up with it
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_q[idx_d];
            PARITY:  tx_d = parity_q;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == '0);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            frame_cnt_q <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx      <= tx_d;
            busy    <= busy_d;
            done    <= done_d;
            if (accept) begin
                data_q   <= in_data;
                parity_q <= (^in_data) ^ odd_sel;
            end
            if (done_d) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Directed bench for parity_tx_ctrl: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_parity_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        odd_sel;
    logic        valid4, valid1;
    logic        rdy4, tx4, busy4, done4;
    logic        rdy1, tx1, busy1, done1;
    logic [15:0] cnt4, cnt1;

    int total = 0;
    int pass  = 0;

    always #5 clk = ~clk;

    parity_tx_ctrl #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid4), .odd_sel(odd_sel),
        .in_ready(rdy4), .tx(tx4), .busy(busy4), .done(done4), .frame_cnt(cnt4)
    );

    parity_tx_ctrl #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid1), .odd_sel(odd_sel),
        .in_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1), .frame_cnt(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for a single cycle; returns in the first START cycle
    task automatic send(input bit which, input logic [7:0] d, input logic odd);
        in_data = d;
        odd_sel = odd;
        if (which) valid1 = 1'b1; else valid4 = 1'b1;
        tick();
        valid1 = 1'b0;
        valid4 = 1'b0;
    endtask

    // Sample tx mid-bit over one whole frame; returns in the cycle after the frame
    task automatic capture(input bit which, output logic [10:0] bits, output int busy_n,
                           output int done_n, output bit done_last);
        int c = which ? 1 : 4;
        bits = '0;
        busy_n = 0;
        done_n = 0;
        done_last = 1'b0;
        for (int k = 0; k < 11 * c; k++) begin
            if (k % c == c / 2) bits[k / c] = which ? tx1 : tx4;
            if (which ? busy1 : busy4) busy_n++;
            if (which ? done1 : done4) begin
                done_n++;
                done_last = (k == 11 * c - 1);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid4 = 1'b1;
        valid1 = 1'b1;
        in_data = 8'h55;
        odd_sel = 1'b0;
        tick();
        tick();
        valid4 = 1'b0;
        valid1 = 1'b0;
        rst = 1'b0;
        total++; if ({tx4, busy4, done4, rdy4} !== 4'b1001) $display("FAIL reset4 tx/busy/done/rdy got %b want 1001", {tx4, busy4, done4, rdy4}); else pass++;
        total++; if ({tx1, busy1, done1, rdy1} !== 4'b1001) $display("FAIL reset1 tx/busy/done/rdy got %b want 1001", {tx1, busy1, done1, rdy1}); else pass++;
        total++; if (cnt4 !== 16'd0 || cnt1 !== 16'd0) $display("FAIL reset_cnt got %h/%h want 0000/0000", cnt4, cnt1); else pass++;
    endtask

    task automatic test_basic();
        logic [10:0] bits;
        int bn, dn;
        bit dl;
        send(1'b0, 8'hA5, 1'b0);
        in_data = 8'h00;
        capture(1'b0, bits, bn, dn, dl);
        // start, A5 LSB first, even parity 0, stop
        total++; if (bits !== {1'b1, 1'b0, 8'hA5, 1'b0}) $display("FAIL basic_bits got %b want %b", bits, {1'b1, 1'b0, 8'hA5, 1'b0}); else pass++;
        total++; if (bn !== 44) $display("FAIL basic_busy got %0d want 44", bn); else pass++;
        total++; if (dn !== 1 || !dl) $display("FAIL basic_done got %0d last=%0b want 1 last=1", dn, dl); else pass++;
        total++; if (cnt4 !== 16'd1) $display("FAIL basic_cnt got %0d want 1", cnt4); else pass++;
        total++; if ({tx4, busy4, done4, rdy4} !== 4'b1001) $display("FAIL basic_idle got %b want 1001", {tx4, busy4, done4, rdy4}); else pass++;
    endtask

    task automatic test_parity_mode();
        logic [10:0] bits;
        int bn, dn;
        bit dl;
        send(1'b0, 8'h07, 1'b0);
        odd_sel = 1'b1;
        in_data = 8'hF0;
        capture(1'b0, bits, bn, dn, dl);
        total++; if (bits !== {1'b1, 1'b1, 8'h07, 1'b0}) $display("FAIL even07_bits got %b want %b", bits, {1'b1, 1'b1, 8'h07, 1'b0}); else pass++;
        send(1'b0, 8'h07, 1'b1);
        odd_sel = 1'b0;
        in_data = 8'hF0;
        capture(1'b0, bits, bn, dn, dl);
        total++; if (bits !== {1'b1, 1'b0, 8'h07, 1'b0}) $display("FAIL odd07_bits got %b want %b", bits, {1'b1, 1'b0, 8'h07, 1'b0}); else pass++;
        total++; if (cnt4 !== 16'd3) $display("FAIL parity_cnt got %0d want 3", cnt4); else pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        logic [10:0] exp   [3] = '{{1'b1, 1'b0, 8'h00, 1'b0}, {1'b1, 1'b0, 8'hFF, 1'b0}, {1'b1, 1'b0, 8'h3C, 1'b0}};
        logic [10:0] bits;
        int bn, dn;
        bit dl;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        odd_sel = 1'b0;
        in_data = bytes[0];
        valid4 = 1'b1;
        tick();
        for (int f = 0; f < 3; f++) begin
            if (f < 2) in_data = bytes[f + 1]; else valid4 = 1'b0;
            capture(1'b0, bits, bn, dn, dl);
            total++; if (bits !== exp[f] || bn !== 44) $display("FAIL b2b_frame%0d got %b busy=%0d want %b busy=44", f, bits, bn, exp[f]); else pass++;
            total++; if ({tx4, busy4, rdy4} !== 3'b101) $display("FAIL b2b_gap%0d tx/busy/rdy got %b want 101", f, {tx4, busy4, rdy4}); else pass++;
            if (f < 2) tick();
        end
        tick();
        total++; if (cnt4 !== 16'd3 || busy4 !== 1'b0) $display("FAIL b2b_cnt got %0d busy=%0b want 3 busy=0", cnt4, busy4); else pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits;
        int bn, dn;
        bit dl;
        int late_done = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(1'b0, 8'h5A, 1'b0);
        // 4 start cycles + 3 data bits, then into the middle of bit 3
        for (int k = 0; k < 17; k++) tick();
        total++; if (tx4 !== 1'b1 || busy4 !== 1'b1) $display("FAIL mid_bit3 tx/busy got %b%b want 11", tx4, busy4); else pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({tx4, busy4, done4, rdy4} !== 4'b1001) $display("FAIL mid_abort got %b want 1001", {tx4, busy4, done4, rdy4}); else pass++;
        for (int k = 0; k < 50; k++) begin
            if (done4) late_done++;
            tick();
        end
        total++; if (late_done !== 0 || cnt4 !== 16'd0) $display("FAIL mid_nodone got done=%0d cnt=%0d want 0/0", late_done, cnt4); else pass++;
        send(1'b0, 8'h5A, 1'b0);
        capture(1'b0, bits, bn, dn, dl);
        total++; if (bits !== {1'b1, 1'b0, 8'h5A, 1'b0} || cnt4 !== 16'd1) $display("FAIL mid_resend got %b cnt=%0d want %b cnt=1", bits, cnt4, {1'b1, 1'b0, 8'h5A, 1'b0}); else pass++;
    endtask

    task automatic test_one_clk_per_bit();
        logic [10:0] bits;
        int bn, dn;
        bit dl;
        send(1'b1, 8'h80, 1'b0);
        capture(1'b1, bits, bn, dn, dl);
        total++; if (bits !== 11'b111_0000_0000) $display("FAIL c1_bits got %b want 11100000000", bits); else pass++;
        total++; if (bn !== 11 || dn !== 1 || !dl) $display("FAIL c1_timing got busy=%0d done=%0d want 11/1", bn, dn); else pass++;
        total++; if ({tx1, busy1, rdy1} !== 3'b101 || cnt1 !== 16'd1) $display("FAIL c1_idle got %b cnt=%0d want 101 cnt=1", {tx1, busy1, rdy1}, cnt1); else pass++;
    endtask

    task automatic test_wrap();
        logic [10:0] bits;
        int bn, dn;
        bit dl;
        force dut1.frame_cnt_q = 16'hFFFF;
        tick();
        release dut1.frame_cnt_q;
        tick();
        total++; if (cnt1 !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", cnt1); else pass++;
        send(1'b1, 8'h3C, 1'b0);
        capture(1'b1, bits, bn, dn, dl);
        total++; if (cnt1 !== 16'h0000 || dn !== 1) $display("FAIL wrap_cnt got %h done=%0d want 0000 done=1", cnt1, dn); else pass++;
    endtask

    initial begin
        rst = 1'b1;
        valid4 = 1'b0;
        valid1 = 1'b0;
        in_data = 8'h00;
        odd_sel = 1'b0;
        test_reset();
        test_basic();
        test_parity_mode();
        test_back_to_back();
        test_reset_mid_frame();
        test_one_clk_per_bit();
        test_wrap();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
